prefix_and_pipe: RTL and testbench
==================================

Name: prefix_and_pipe

Overview:
- Pipelined, handshaked successor to the combinational Sklansky prefix-AND structure.
- Computes PO[i] = PI[0] op PI[1] op ... op PI[i], where op is AND or OR and is chosen per transaction.
- Registers are inserted after every `levelsPerStage` prefix levels.
- Used by wide comparators, leading-one/zero detectors and incrementers that cannot close timing with a single-cycle prefix.

Parameters:
- width, 8, operand width (>=1; non-powers of two allowed).
- levelsPerStage, 2, Sklansky levels per pipeline stage (>=1).
- Derived (not overridable): m = $clog2(width); L = max(1, ceil(m/levelsPerStage)) = latency in cycles and number of register stages.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- InValid  in  1  input transaction valid.
- InReady  out  1  block accepts input this cycle.
- Op  in  lau_pkg::prefix_op_e  OP_AND or OP_OR; sampled with PI.
- PI  in  width  operand.
- OutValid  out  1  result valid.
- OutReady  in  1  downstream accepts result.
- PO  out  width  prefix result.

Behaviour:
- Reset:
  - One clock with RST=1 clears every stage valid bit, so OutValid=0 and PO=0 the following cycle.
  - Data registers are also cleared to 0.
  - RST overrides all handshakes. Transactions in flight at reset are discarded and never emitted.
- Levels:
  - Level 0 = PI.
  - Level l (1..m) is Sklansky: for group k and bit i < 2^(l-1), PT_l[k*2^l+2^(l-1)+i] = PT_(l-1)[same] op PT_(l-1)[k*2^l+2^(l-1)-1].
  - All other bits pass through.
  - Indices >= width are pruned.
- Staging:
  - Stage s (1..L) computes levels (s-1)*levelsPerStage+1 .. min(s*levelsPerStage, m), then registers the result.
  - Stage L always ends in a register, so PO is always registered.
  - width=1 gives m=0 and L=1: PO=PI delayed one cycle.
- OR mode is the same prefix with op = OR, implemented by De Morgan on the AND network (invert in, invert out). Op travels with the data through every stage register.
- Handshake, stall-all pipeline:
  - en = ~OutValid | OutReady.
  - InReady = en. This is combinational from OutValid/OutReady, with no path from InValid.
  - When en=1, every stage register loads from its predecessor. The stage-1 valid bit loads InValid & InReady.
  - When en=0, all stages hold, and PO/OutValid stay stable.
- Interior bubbles are not collapsed. Throughput is one result per cycle while OutReady=1.
- Latency: a transaction accepted in cycle t appears with OutValid=1 in cycle t+L if not stalled. Each stall cycle adds one cycle.
- Ordering is strictly FIFO. No transaction is lost or duplicated under any OutReady pattern.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle are both honoured; the pipeline advances by one.
  - RST asserted in the same cycle as InValid: the input is dropped.

Decomposition:
- lau_pkg gains:
  - typedef enum logic {OP_AND, OP_OR} prefix_op_e.
  - function prefix_latency(width, levelsPerStage), returning L. Used by this block and its parents.
- One combinational sub-module, prefix_and_levels:
  - parameters width, firstLevel, lastLevel; ports PI, PO.
  - Implements Sklansky levels firstLevel..lastLevel.
  - Instantiated once per stage; the top level holds only the registers and handshake logic.

Test Plan:
- width=8, lps=2 (L=2), OutReady=1: Op=AND, PI=8'hEF -> PO=8'h0F with OutValid exactly 2 cycles after acceptance.
- Same configuration: Op=OR, PI=8'h10 -> PO=8'hF0. Back-to-back AND 8'hFF then OR 8'h00 -> 8'hFF then 8'h00 on consecutive cycles.
- Backpressure: OutReady=0, with 8'h01, 8'h03, 8'h07 offered (AND) -> at most L transactions held, and InReady=0 once OutValid=1. Release OutReady -> 8'h01, 8'h03, 8'h07 in order with no gaps and no duplicates.
- Random OutReady: 1000 random PI/Op with random OutReady at 50% duty, checked against a serial reference model -> outputs match in order; PO is stable whenever OutValid & ~OutReady.
- Non-power-of-two width=13, lps=1 (L=4): AND with PI=13'h1F7F -> PO=13'h007F. OR with PI=13'h0400 -> PO=13'h1C00.
- Reset: assert RST for one cycle with 2 transactions in flight -> next cycle OutValid=0 and PO=0; no stale result ever appears; the first post-reset input emerges after L cycles.

Source files
------------

// File: rtl/lau_pkg.sv
// lau_pkg: shared prefix operator type and latency helper for the prefix blocks
package lau_pkg;
  typedef enum logic {OP_AND, OP_OR} prefix_op_e;
  function automatic int prefix_latency(int width, int levelsPerStage);
    int m = $clog2(width);
    return m == 0 ? 1 : (m + levelsPerStage - 1) / levelsPerStage;
  endfunction
endpackage

// File: rtl/prefix_and_levels.sv
// prefix_and_levels: combinational Sklansky prefix-AND levels firstLevel..lastLevel
//   PI: level firstLevel-1 vector, PO: level lastLevel vector (pass-through when the range is empty)
module prefix_and_levels #(
  parameter int width = 8,
  parameter int firstLevel = 1,
  parameter int lastLevel = 3
) (
  input  logic [width-1:0] PI,
  output logic [width-1:0] PO
);
  logic [width-1:0] cur, prev;
  always_comb begin
    cur = PI;
    prev = PI;
    for (int l = firstLevel; l <= lastLevel; l++) begin
      prev = cur;
      for (int b = 0; b < width; b++)
        cur[b] = b[l-1] ? prev[b] & prev[((b >> l) << l) + (1 << (l - 1)) - 1] : prev[b];
    end
    PO = cur;
  end
endmodule

// File: rtl/prefix_and_pipe.sv
// prefix_and_pipe: pipelined, stall-all handshaked Sklansky prefix AND/OR
//   CLK/RST: clock, sync active-high reset; InValid/InReady/Op/PI: input channel;
//   OutValid/OutReady/PO: registered result channel, latency prefix_latency(width, levelsPerStage)
module prefix_and_pipe
  import lau_pkg::*;
#(
  parameter int width = 8,
  parameter int levelsPerStage = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  prefix_op_e       Op,
  input  logic [width-1:0] PI,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [width-1:0] PO
);
  localparam int M = $clog2(width);
  localparam int L = prefix_latency(width, levelsPerStage);
  logic [L-1:0] vld_q, vld_d, or_q, or_d;
  logic [L-1:0][width-1:0] data_q, data_d, stage_in;
  logic en;
  assign en = ~OutValid | OutReady;
  assign InReady = en;
  assign OutValid = vld_q[L-1];
  // OR runs on the AND network in the complemented domain: invert on entry, invert on exit
  assign PO = or_q[L-1] ? ~data_q[L-1] : data_q[L-1];
  assign stage_in = (L*width)'({data_q, (Op == OP_OR) ? ~PI : PI});
  assign vld_d = L'({vld_q, InValid & InReady});
  assign or_d = L'({or_q, Op == OP_OR});
  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int lo = s * levelsPerStage + 1;
    localparam int hi = (s + 1) * levelsPerStage < M ? (s + 1) * levelsPerStage : M;
    prefix_and_levels #(.width(width), .firstLevel(lo), .lastLevel(hi)) u_lvl (
      .PI(stage_in[s]),
      .PO(data_d[s])
    );
  end
  always_ff @(posedge CLK)
    if (RST) begin
      vld_q <= '0;
      or_q <= '0;
      data_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      or_q <= or_d;
      data_q <= data_d;
    end
endmodule

// File: tb/tb_prefix_and_pipe.sv
// tb_prefix_and_pipe: scoreboard bench for prefix_and_pipe (8/2 and 13/1 instances)
module tb_prefix_and_pipe;
  import lau_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, ta, tb;
  bit lat_chk = 1, rnd_or = 0;
  logic a_iv = 0, a_ir, a_ov, a_or = 1;
  prefix_op_e a_op = OP_AND;
  logic [7:0] a_pi = '0, a_po, a_exp = '0, hold_po;
  bit hold_v = 0;
  logic b_iv = 0, b_ir, b_ov, b_or = 1;
  prefix_op_e b_op = OP_AND;
  logic [12:0] b_pi = '0, b_po, b_exp = '0;
  logic [7:0] qa[$];
  logic [12:0] qb[$];
  int qa_c[$], qb_c[$];

  prefix_and_pipe #(.width(8), .levelsPerStage(2)) dut_a (
    .CLK(clk), .RST(rst), .InValid(a_iv), .InReady(a_ir), .Op(a_op), .PI(a_pi),
    .OutValid(a_ov), .OutReady(a_or), .PO(a_po));
  prefix_and_pipe #(.width(13), .levelsPerStage(1)) dut_b (
    .CLK(clk), .RST(rst), .InValid(b_iv), .InReady(b_ir), .Op(b_op), .PI(b_pi),
    .OutValid(b_ov), .OutReady(b_or), .PO(b_po));

  always @(posedge clk) cyc++;
  always @(posedge clk) if (rnd_or) #1 a_or = 1'($urandom_range(0, 1));
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref8(logic [7:0] v, bit is_or);
    logic acc = !is_or;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      acc = is_or ? acc | v[i] : acc & v[i];
      r[i] = acc;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qa_c.delete();
      hold_v = 0;
    end else begin
      if (hold_v && a_ov) chk("a_stall_stable", a_po, hold_po);
      hold_v = a_ov && !a_or;
      hold_po = a_po;
      if (a_ov && a_or) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected: got %0h expected no output", a_po);
        end else begin
          chk("a_po", a_po, qa.pop_front());
          ta = qa_c.pop_front();
          if (lat_chk) chk("a_latency", cyc - ta, 2);
        end
      end
      if (a_iv && a_ir) begin
        qa.push_back(a_exp);
        qa_c.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      qb_c.delete();
    end else begin
      if (b_ov && b_or) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got %0h expected no output", b_po);
        end else begin
          chk("b_po", b_po, qb.pop_front());
          tb = qb_c.pop_front();
          chk("b_latency", cyc - tb, 4);
        end
      end
      if (b_iv && b_ir) begin
        qb.push_back(b_exp);
        qb_c.push_back(cyc);
      end
    end
  end

  task automatic send_a(prefix_op_e op, logic [7:0] pi, logic [7:0] exp);
    int n = 0;
    a_iv = 1;
    a_op = op;
    a_pi = pi;
    a_exp = exp;
    @(negedge clk);
    while (!a_ir && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_ir) begin
      checks++;
      errors++;
      $display("FAIL a_send_timeout: InReady got 0 expected 1");
      a_iv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(prefix_op_e op, logic [12:0] pi, logic [12:0] exp);
    int n = 0;
    b_iv = 1;
    b_op = op;
    b_pi = pi;
    b_exp = exp;
    @(negedge clk);
    while (!b_ir && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b_ir) begin
      checks++;
      errors++;
      $display("FAIL b_send_timeout: InReady got 0 expected 1");
      b_iv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", qa.size() + qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("a_reset_ov", a_ov, 0);
    chk("a_reset_po", a_po, 0);
    chk("b_reset_ov", b_ov, 0);
    chk("b_reset_po", b_po, 0);
    @(posedge clk);
    #1;
    send_a(OP_AND, 8'hEF, 8'h0F);
    send_a(OP_OR, 8'h10, 8'hF0);
    send_a(OP_AND, 8'hFF, 8'hFF);
    send_a(OP_OR, 8'h00, 8'h00);
    a_iv = 0;
    send_b(OP_AND, 13'h1F7F, 13'h007F);
    send_b(OP_OR, 13'h0400, 13'h1C00);
    send_b(OP_AND, 13'h1FFF, 13'h1FFF);
    b_iv = 0;
    drain();
    lat_chk = 0;
    a_or = 0;
    send_a(OP_AND, 8'h01, 8'h01);
    send_a(OP_AND, 8'h03, 8'h03);
    a_iv = 1;
    a_pi = 8'h07;
    a_exp = 8'h07;
    repeat (4) begin
      @(negedge clk);
      chk("a_bp_inready", a_ir, 0);
      chk("a_bp_outvalid", a_ov, 1);
    end
    chk("a_bp_held", qa.size(), 2);
    @(posedge clk);
    #1 a_or = 1;
    send_a(OP_AND, 8'h07, 8'h07);
    a_iv = 0;
    drain();
    rnd_or = 1;
    for (int i = 0; i < 1000; i++) begin
      prefix_op_e op = prefix_op_e'($urandom_range(0, 1));
      logic [7:0] pi = 8'($urandom);
      send_a(op, pi, ref8(pi, op == OP_OR));
    end
    a_iv = 0;
    rnd_or = 0;
    @(posedge clk);
    #1 a_or = 1;
    drain();
    a_or = 0;
    send_a(OP_AND, 8'h0F, 8'h0F);
    send_a(OP_OR, 8'h01, 8'hFF);
    a_iv = 1;
    a_pi = 8'hAA;
    a_exp = 8'hAA;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    a_iv = 0;
    a_or = 1;
    @(negedge clk);
    chk("a_rst_flush_ov", a_ov, 0);
    chk("a_rst_flush_po", a_po, 0);
    repeat (4) begin
      @(negedge clk);
      chk("a_no_stale", a_ov, 0);
    end
    @(posedge clk);
    #1 lat_chk = 1;
    send_a(OP_AND, 8'h3F, 8'h3F);
    a_iv = 0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
